// File: rtl/victim_cache_control.sv
// Sequencing FSM for the 4-entry victim cache: serves L2 read misses from the
// victim entries or pmem, installs L2 evictions, and forwards L2 write-backs.
module victim_cache_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l2_vc_read,
  input  logic             l2_vc_write,
  input  logic             l2_vc_victim_valid,
  output logic             l2_vc_resp,
  input  logic             hit,
  output logic             update_victim,
  output logic             rdata_sel,
  output logic             vc_pmem_read,
  output logic             vc_pmem_write,
  input  logic             vc_pmem_resp,
  output logic [CNT_W-1:0] vc_hit_count,
  output logic [CNT_W-1:0] vc_miss_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HIT       = 3'd1,
    FETCH     = 3'd2,
    WRITEBACK = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             hit_inc, miss_inc;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (l2_vc_write)           state_d = WRITEBACK;
        else if (l2_vc_read && hit) state_d = HIT;
        else if (l2_vc_read)        state_d = FETCH;
      end
      HIT:       state_d = DONE;
      FETCH:     if (vc_pmem_resp) state_d = DONE;
      WRITEBACK: if (vc_pmem_resp) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Mealy outputs; a reset cycle suppresses the aborted access entirely.
  always_comb begin
    l2_vc_resp    = 1'b0;
    update_victim = 1'b0;
    rdata_sel     = 1'b0;
    vc_pmem_read  = 1'b0;
    vc_pmem_write = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        HIT: begin
          rdata_sel     = 1'b1;
          l2_vc_resp    = 1'b1;
          update_victim = l2_vc_victim_valid;
          hit_inc       = 1'b1;
        end
        FETCH: begin
          vc_pmem_read  = 1'b1;
          l2_vc_resp    = vc_pmem_resp;
          update_victim = vc_pmem_resp & l2_vc_victim_valid;
          miss_inc      = vc_pmem_resp;
        end
        WRITEBACK: begin
          vc_pmem_write = 1'b1;
          l2_vc_resp    = vc_pmem_resp;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc)  hit_cnt_d  = hit_cnt_q + CNT_W'(1);
    if (miss_inc) miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign vc_hit_count  = hit_cnt_q;
  assign vc_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_victim_cache_control.sv
// Randomized access-level bench for victim_cache_control (CNT_W=4 build).
module tb_victim_cache_control;
  localparam int unsigned CNT_W = 4;
  localparam int MASK = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, l2_vc_read, l2_vc_write, l2_vc_victim_valid, hit, vc_pmem_resp;
  logic l2_vc_resp, update_victim, rdata_sel, vc_pmem_read, vc_pmem_write;
  logic [CNT_W-1:0] vc_hit_count, vc_miss_count;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  victim_cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .l2_vc_read(l2_vc_read), .l2_vc_write(l2_vc_write),
    .l2_vc_victim_valid(l2_vc_victim_valid), .l2_vc_resp(l2_vc_resp),
    .hit(hit), .update_victim(update_victim), .rdata_sel(rdata_sel),
    .vc_pmem_read(vc_pmem_read), .vc_pmem_write(vc_pmem_write),
    .vc_pmem_resp(vc_pmem_resp),
    .vc_hit_count(vc_hit_count), .vc_miss_count(vc_miss_count)
  );

  always #5 clk = ~clk;

  // Output bundle: {resp, update_victim, rdata_sel, pmem_read, pmem_write}
  wire [4:0] outs = {l2_vc_resp, update_victim, rdata_sel, vc_pmem_read, vc_pmem_write};

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (vc_pmem_read && vc_pmem_write) begin
        errors++;
        $display("FAIL pmem_overlap: read=%b write=%b, required not both high", vc_pmem_read, vc_pmem_write);
      end
      checks++;
      if (rdata_sel && !l2_vc_resp) begin
        errors++;
        $display("FAIL rdata_sel_only_hit: rdata_sel=1 resp=0, required rdata_sel only with a hit response");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic h, input logic vv, input logic pr);
    l2_vc_read = r; l2_vc_write = w; hit = h; l2_vc_victim_valid = vv; vc_pmem_resp = pr;
  endtask

  // Called in an IDLE cycle with no request; checks counters and spends that cycle.
  task automatic idle_check(input string name);
    drive(0, 0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    #3;
    checks++;
    if (outs !== 5'b0 || vc_hit_count !== CNT_W'(exp_hits) || vc_miss_count !== CNT_W'(exp_misses)) begin
      errors++;
      $display("FAIL %s_idle: outs=%b hits=%0d misses=%0d, required outs=00000 hits=%0d misses=%0d",
               name, outs, vc_hit_count, vc_miss_count, exp_hits, exp_misses);
    end
    tick();
  endtask

  // One L2 read starting in IDLE: hit served next cycle, miss after lat pmem cycles.
  task automatic run_read(input bit is_hit, input bit vv, input int lat, input bit gap, input string name);
    logic [4:0] exp;
    drive(1, 0, is_hit, vv, 0);
    #3;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL %s_req_cycle: outs=%b, required 00000", name, outs);
    end
    tick();
    if (is_hit) begin
      drive(1, 0, 1, vv, 1'($urandom_range(0, 1)));
      #3;
      exp = {1'b1, vv, 1'b1, 1'b0, 1'b0};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL %s_hit_cycle: outs=%b, required %b", name, outs, exp);
      end
      exp_hits = (exp_hits + 1) & MASK;
      tick();
    end else begin
      for (int k = 1; k <= lat; k++) begin
        drive(1, 0, 0, vv, 1'(k == lat));
        #3;
        exp = {1'(k == lat), 1'(k == lat && vv), 1'b0, 1'b1, 1'b0};
        checks++;
        if (outs !== exp) begin
          errors++;
          $display("FAIL %s_fetch_cycle%0d: outs=%b, required %b", name, k, outs, exp);
        end
        tick();
      end
      exp_misses = (exp_misses + 1) & MASK;
    end
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), vv,
          1'($urandom_range(0, 1)));
    #3;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL %s_done_cycle: outs=%b, required 00000", name, outs);
    end
    tick();
    if (gap) idle_check(name);
  endtask

  // L2 write-back starting in IDLE; keep_read holds a concurrent read pending.
  task automatic run_write(input bit keep_read, input int lat, input string name);
    logic [4:0] exp;
    drive(keep_read, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    #3;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL %s_req_cycle: outs=%b, required 00000", name, outs);
    end
    tick();
    for (int k = 1; k <= lat; k++) begin
      drive(keep_read, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(k == lat));
      #3;
      exp = {1'(k == lat), 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL %s_wb_cycle%0d: outs=%b, required %b", name, k, outs, exp);
      end
      tick();
    end
    drive(keep_read, 0, 0, 0, 1'($urandom_range(0, 1)));
    #3;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL %s_done_cycle: outs=%b, required 00000", name, outs);
    end
    tick();
    if (!keep_read) idle_check(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    idle_check("reset");
  endtask

  task automatic test_miss();
    run_read(0, 1, 4, 1, "miss_lat4");
    checks++;
    if (vc_miss_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL miss_count_first: got %0d, required 1", vc_miss_count);
    end
  endtask

  task automatic test_hit();
    run_read(0, 1, 2, 1, "install_1000");
    run_read(1, 1, 0, 1, "hit_1000");
    checks++;
    if (vc_hit_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL hit_count_first: got %0d, required 1", vc_hit_count);
    end
  endtask

  task automatic test_write_priority();
    run_write(1, 3, "rw_wb");
    run_read(0, 1, 2, 1, "rw_read_miss");
    run_write(1, 1, "rw_wb2");
    run_read(1, 0, 0, 1, "rw_read_hit");
    run_write(0, 5, "wb_only");
  endtask

  task automatic test_no_victim();
    run_read(0, 0, 3, 1, "miss_novictim");
    run_read(1, 0, 0, 1, "hit_novictim");
  endtask

  task automatic test_reset_mid_fetch();
    for (int v = 0; v < 2; v++) begin
      drive(1, 0, 0, 1, 0);
      tick();
      drive(1, 0, 0, 1, 0);
      #3;
      checks++;
      if (outs !== 5'b00010) begin
        errors++;
        $display("FAIL rst_fetch_c1_v%0d: outs=%b, required 00010", v, outs);
      end
      tick();
      rst = 1'b1;
      drive(1, 0, 0, 1, 1'(v));
      #3;
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("FAIL rst_fetch_c2_v%0d: outs=%b, required 00000", v, outs);
      end
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 1, 1);
      #3;
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("FAIL rst_after_v%0d: outs=%b, required 00000", v, outs);
      end
      tick();
      exp_hits = 0;
      exp_misses = 0;
      idle_check("rst_mid_fetch");
    end
  endtask

  task automatic test_back_to_back();
    run_read(1, 1, 0, 0, "b2b_hit0");
    run_read(1, 0, 0, 0, "b2b_hit1");
    run_read(0, 1, 1, 0, "b2b_miss");
    run_read(1, 1, 0, 1, "b2b_hit2");
  endtask

  task automatic test_wrap();
    while (exp_hits != MASK) run_read(1, 1, 0, 0, "wrap_fill");
    idle_check("wrap_full");
    run_read(1, 1, 0, 1, "wrap_hit");
    checks++;
    if (vc_hit_count !== CNT_W'(0)) begin
      errors++;
      $display("FAIL hit_count_wrap: got %0d, required 0", vc_hit_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 3);
      int lat = $urandom_range(1, 6);
      bit vv = 1'($urandom_range(0, 1));
      bit gap = 1'($urandom_range(0, 1));
      case (kind)
        0: run_read(1, vv, 0, gap, "rnd_hit");
        1: run_read(0, vv, lat, gap, "rnd_miss");
        2: run_write(0, lat, "rnd_wb");
        default: begin
          run_write(1, lat, "rnd_rw_wb");
          run_read(1'($urandom_range(0, 1)), vv, $urandom_range(1, 6), 1, "rnd_rw_read");
        end
      endcase
    end
    idle_check("rnd_end");
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_miss();
    test_hit();
    test_write_priority();
    test_no_victim();
    test_reset();
    test_reset_mid_fetch();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
